// File: rtl/pool_pkg.sv
// Shared types and constants for the pooling address generator.
// Holds the FSM state enum, the latched job config and lane indices.
package pool_pkg;

  localparam int POOL_ADDR_W  = 5;
  localparam int POOL_MAX_DIM = 5;
  localparam int POOL_DIM_W   = $clog2(POOL_MAX_DIM + 1);

  localparam logic [1:0] TL = 2'd0;
  localparam logic [1:0] TR = 2'd1;
  localparam logic [1:0] BL = 2'd2;
  localparam logic [1:0] BR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } pool_state_e;

  typedef struct packed {
    logic [POOL_DIM_W-1:0]  dim;
    logic [POOL_ADDR_W-1:0] base;
    logic                   stride1;
    logic                   mode;
  } pool_cfg_t;

endpackage

// File: rtl/pool_win_counter.sv
// Window origin counters: row r, column c and row offset r*N.
// Ports: clr restarts at (0,0); adv steps one window; last_o flags final.
module pool_win_counter #(
  parameter int ADDR_W = 5,
  parameter int DIM_W  = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clr,
  input  logic              adv,
  input  logic [DIM_W-1:0]  dim_i,
  input  logic              stride1_i,
  output logic [DIM_W-1:0]  r_o,
  output logic [DIM_W-1:0]  c_o,
  output logic [ADDR_W-1:0] rb_o,
  output logic              last_o
);

  logic [DIM_W-1:0]  r_q, r_d;
  logic [DIM_W-1:0]  c_q, c_d;
  logic [ADDR_W-1:0] rb_q, rb_d;

  logic [DIM_W:0]    step;
  logic [DIM_W:0]    lim;
  logic [DIM_W:0]    c_nx;
  logic [DIM_W:0]    r_nx;
  logic              c_wrap;
  logic              r_end;
  logic [ADDR_W-1:0] n_a;
  logic [ADDR_W-1:0] rb_step;

  always_comb begin
    // stride 1 stops origins at N-2, stride 2 at the last even < N
    step    = stride1_i ? (DIM_W+1)'(1) : (DIM_W+1)'(2);
    lim     = stride1_i ? {1'b0, dim_i} - (DIM_W+1)'(1)
                        : {1'b0, dim_i};
    c_nx    = {1'b0, c_q} + step;
    r_nx    = {1'b0, r_q} + step;
    c_wrap  = c_nx >= lim;
    r_end   = r_nx >= lim;
    n_a     = ADDR_W'(dim_i);
    rb_step = stride1_i ? n_a : n_a + n_a;

    r_d  = r_q;
    c_d  = c_q;
    rb_d = rb_q;
    if (clr) begin
      r_d  = '0;
      c_d  = '0;
      rb_d = '0;
    end else if (adv) begin
      if (c_wrap) begin
        c_d  = '0;
        r_d  = r_nx[DIM_W-1:0];
        rb_d = rb_q + rb_step;
      end else begin
        c_d  = c_nx[DIM_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_q  <= '0;
      c_q  <= '0;
      rb_q <= '0;
    end else begin
      r_q  <= r_d;
      c_q  <= c_d;
      rb_q <= rb_d;
    end
  end

  assign r_o    = r_q;
  assign c_o    = c_q;
  assign rb_o   = rb_q;
  assign last_o = c_wrap && r_end;

endmodule

// File: rtl/pool_addr_gen.sv
// Pooling sequencer: one 2x2 window (4 addrs, pad mask, last) per handshake.
// Ports: start/dim/base/mode/stride1 job in; win_* out; busy/done/err status.
// Macro POOL_STRIDE1_EN enables stride 1; otherwise stride is fixed at 2.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int ADDR_W  = POOL_ADDR_W,
  parameter int MAX_DIM = POOL_MAX_DIM,
  parameter int DIM_W   = $clog2(MAX_DIM + 1),
  parameter logic [ADDR_W-1:0] PAD_ADDR = '1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              mode_i,
  input  logic              stride1_i,
  input  logic [DIM_W-1:0]  dim_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic              busy,
  output logic              win_vld,
  input  logic              win_rdy,
  output logic [ADDR_W-1:0] addr_o [4],
  output logic [3:0]        pad_o,
  output logic              mode_o,
  output logic              last_o,
  output logic              done,
  output logic              err
);

  pool_state_e state_q, state_d;
  pool_cfg_t   cfg_q, cfg_d;
  logic        err_q, err_d;
  logic        clr;
  logic        hs;
  logic        dim_ok;
  logic        last_w;

  logic [DIM_W-1:0]  dim_q;
  logic [DIM_W-1:0]  r;
  logic [DIM_W-1:0]  c;
  logic [ADDR_W-1:0] rb_off;
  logic [ADDR_W-1:0] rb;
  logic [ADDR_W-1:0] n_a;
  logic [ADDR_W-1:0] c_a;
  logic [ADDR_W-1:0] raw [4];
  logic [3:0]        pad;
  logic              c_end;
  logic              r_end;

`ifndef POOL_STRIDE1_EN
  logic unused_stride1;
  assign unused_stride1 = stride1_i;
`endif

  assign dim_ok  = (dim_i >= DIM_W'(2)) &&
                   (dim_i <= DIM_W'(MAX_DIM));
  assign win_vld = state_q == ST_RUN;
  assign hs      = win_vld && win_rdy;
  assign dim_q   = DIM_W'(cfg_q.dim);

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    err_d   = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dim_ok) begin
            cfg_d.dim  = POOL_DIM_W'(dim_i);
            cfg_d.base = POOL_ADDR_W'(base_i);
            cfg_d.mode = mode_i;
`ifdef POOL_STRIDE1_EN
            cfg_d.stride1 = stride1_i;
`else
            cfg_d.stride1 = 1'b0;
`endif
            clr     = 1'b1;
            state_d = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (hs && last_w) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
    end
  end

  pool_win_counter #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_cnt (
    .clk       (clk),
    .nrst      (nrst),
    .clr       (clr),
    .adv       (hs),
    .dim_i     (dim_q),
    .stride1_i (cfg_q.stride1),
    .r_o       (r),
    .c_o       (c),
    .rb_o      (rb_off),
    .last_o    (last_w)
  );

  always_comb begin
    n_a   = ADDR_W'(dim_q);
    c_a   = ADDR_W'(c);
    rb    = ADDR_W'(cfg_q.base) + rb_off;
    c_end = ({1'b0, c} + (DIM_W+1)'(1)) >= {1'b0, dim_q};
    r_end = ({1'b0, r} + (DIM_W+1)'(1)) >= {1'b0, dim_q};

    raw[TL] = rb + c_a;
    raw[TR] = rb + c_a + ADDR_W'(1);
    raw[BL] = rb + n_a + c_a;
    raw[BR] = rb + n_a + c_a + ADDR_W'(1);

    pad     = '0;
    pad[TR] = c_end;
    pad[BL] = r_end;
    pad[BR] = c_end || r_end;

    // outputs read as zero outside RUN so idle matches reset
    for (int k = 0; k < 4; k++) begin
      addr_o[k] = '0;
      if (win_vld) addr_o[k] = pad[k] ? PAD_ADDR : raw[k];
    end
    pad_o  = win_vld ? pad : 4'b0000;
    last_o = win_vld && last_w;
  end

  assign busy   = state_q != ST_IDLE;
  assign done   = state_q == ST_DONE;
  assign err    = err_q;
  assign mode_o = cfg_q.mode;

endmodule

// File: tb/tb_pool_addr_gen.sv
// Directed bench for pool_addr_gen.
// Inputs change and outputs are checked on the falling clock edge.
module tb_pool_addr_gen;

  localparam int P = 31;

  logic       clk = 1'b0;
  logic       nrst;
  logic       start;
  logic       mode_i;
  logic       stride1_i;
  logic [2:0] dim_i;
  logic [4:0] base_i;
  logic       busy;
  logic       win_vld;
  logic       win_rdy;
  logic [4:0] addr_o [4];
  logic [3:0] pad_o;
  logic       mode_o;
  logic       last_o;
  logic       done;
  logic       err;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  pool_addr_gen dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .mode_i    (mode_i),
    .stride1_i (stride1_i),
    .dim_i     (dim_i),
    .base_i    (base_i),
    .busy      (busy),
    .win_vld   (win_vld),
    .win_rdy   (win_rdy),
    .addr_o    (addr_o),
    .pad_o     (pad_o),
    .mode_o    (mode_o),
    .last_o    (last_o),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_win(input string tag,
                            input int a0, input int a1,
                            input int a2, input int a3,
                            input logic [3:0] pd,
                            input logic lst);
    logic [4:0] e0, e1, e2, e3;
    e0 = 5'(a0);
    e1 = 5'(a1);
    e2 = 5'(a2);
    e3 = 5'(a3);
    chk(tag,
        {6'b0, addr_o[0], addr_o[1], addr_o[2], addr_o[3],
         pad_o, last_o, win_vld},
        {6'b0, e0, e1, e2, e3, pd, lst, 1'b1});
    @(negedge clk);
  endtask

  task automatic start_job(input int n, input int b,
                           input logic s1, input logic md);
    start     = 1'b1;
    dim_i     = 3'(n);
    base_i    = 5'(b);
    stride1_i = s1;
    mode_i    = md;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    chk({tag, "_done"}, {29'b0, done, busy, win_vld}, 32'b110);
    @(negedge clk);
    chk({tag, "_idle"}, {29'b0, done, busy, win_vld}, 32'b000);
  endtask

  task automatic bad_start(input string tag, input int n);
    start = 1'b1;
    dim_i = 3'(n);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_err"}, {29'b0, err, busy, win_vld}, 32'b100);
    @(negedge clk);
    chk({tag, "_clr"}, {29'b0, err, busy, win_vld}, 32'b000);
  endtask

  initial begin
    nrst      = 1'b0;
    start     = 1'b0;
    mode_i    = 1'b0;
    stride1_i = 1'b0;
    dim_i     = '0;
    base_i    = '0;
    win_rdy   = 1'b1;

    @(negedge clk);
    chk("reset",
        {6'b0, busy, win_vld, last_o, done, err, mode_o, pad_o,
         addr_o[0], addr_o[1], addr_o[2], addr_o[3]},
        32'b0);
    nrst = 1'b1;
    @(negedge clk);

    // N=3 stride 2 base 0, max mode
    start_job(3, 0, 1'b0, 1'b1);
    chk("n3_mode", {31'b0, mode_o}, 32'd1);
    expect_win("n3_w0", 0, 1, 3, 4, 4'b0000, 1'b0);
    expect_win("n3_w1", 2, P, 5, P, 4'b1010, 1'b0);
    expect_win("n3_w2", 6, 7, P, P, 4'b1100, 1'b0);
    expect_win("n3_w3", 8, P, P, P, 4'b1110, 1'b1);
    expect_done("n3");

    // N=4 stride 2 base 8
    start_job(4, 8, 1'b0, 1'b0);
    chk("n4_mode", {31'b0, mode_o}, 32'd0);
    expect_win("n4_w0", 8, 9, 12, 13, 4'b0000, 1'b0);
    expect_win("n4_w1", 10, 11, 14, 15, 4'b0000, 1'b0);
    expect_win("n4_w2", 16, 17, 20, 21, 4'b0000, 1'b0);
    expect_win("n4_w3", 18, 19, 22, 23, 4'b0000, 1'b1);
    expect_done("n4");

    // N=3 stride 1 request
    start_job(3, 0, 1'b1, 1'b0);
`ifdef POOL_STRIDE1_EN
    expect_win("s1_w0", 0, 1, 3, 4, 4'b0000, 1'b0);
    expect_win("s1_w1", 1, 2, 4, 5, 4'b0000, 1'b0);
    expect_win("s1_w2", 3, 4, 6, 7, 4'b0000, 1'b0);
    expect_win("s1_w3", 4, 5, 7, 8, 4'b0000, 1'b1);
`else
    expect_win("s1_w0", 0, 1, 3, 4, 4'b0000, 1'b0);
    expect_win("s1_w1", 2, P, 5, P, 4'b1010, 1'b0);
    expect_win("s1_w2", 6, 7, P, P, 4'b1100, 1'b0);
    expect_win("s1_w3", 8, P, P, P, 4'b1110, 1'b1);
`endif
    expect_done("s1");

    // back-pressure: 3 stalled edges on window 1
    start_job(4, 8, 1'b0, 1'b0);
    expect_win("bp_w0", 8, 9, 12, 13, 4'b0000, 1'b0);
    win_rdy = 1'b0;
    expect_win("bp_hold0", 10, 11, 14, 15, 4'b0000, 1'b0);
    expect_win("bp_hold1", 10, 11, 14, 15, 4'b0000, 1'b0);
    expect_win("bp_hold2", 10, 11, 14, 15, 4'b0000, 1'b0);
    win_rdy = 1'b1;
    expect_win("bp_w1", 10, 11, 14, 15, 4'b0000, 1'b0);
    expect_win("bp_w2", 16, 17, 20, 21, 4'b0000, 1'b0);
    expect_win("bp_w3", 18, 19, 22, 23, 4'b0000, 1'b1);
    expect_done("bp");

    // rejected starts
    bad_start("dim1", 1);
    bad_start("dim6", 6);

    // reset in the middle of an N=5 job
    start_job(5, 0, 1'b0, 1'b1);
    expect_win("rs_w0", 0, 1, 5, 6, 4'b0000, 1'b0);
    expect_win("rs_w1_pre", 2, 3, 7, 8, 4'b0000, 1'b0);
    nrst = 1'b0;
    #1;
    chk("rs_reset",
        {6'b0, busy, win_vld, last_o, done, err, mode_o, pad_o,
         addr_o[0], addr_o[1], addr_o[2], addr_o[3]},
        32'b0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("rs_nodone", {29'b0, done, busy, win_vld}, 32'b000);
    @(negedge clk);
    chk("rs_nodone2", {29'b0, done, busy, win_vld}, 32'b000);

    // full N=5 job, base 4
    start_job(5, 4, 1'b0, 1'b0);
    expect_win("n5_w0", 4, 5, 9, 10, 4'b0000, 1'b0);
    expect_win("n5_w1", 6, 7, 11, 12, 4'b0000, 1'b0);
    expect_win("n5_w2", 8, P, 13, P, 4'b1010, 1'b0);
    expect_win("n5_w3", 14, 15, 19, 20, 4'b0000, 1'b0);
    expect_win("n5_w4", 16, 17, 21, 22, 4'b0000, 1'b0);
    expect_win("n5_w5", 18, P, 23, P, 4'b1010, 1'b0);
    expect_win("n5_w6", 24, 25, P, P, 4'b1100, 1'b0);
    expect_win("n5_w7", 26, 27, P, P, 4'b1100, 1'b0);
    expect_win("n5_w8", 28, P, P, P, 4'b1110, 1'b1);
    expect_done("n5");

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule

// File: doc/pool_addr_gen.md
# pool_addr_gen

Parametrised address generator and sequencer for the pooling unit. It accepts one pooling job (feature-map dimension, base address, stride, max/avg mode) and emits one 2x2 window per handshake: four buffer read addresses, a per-lane pad mask, and a last-window flag. It sits between the layer controller and the pooling datapath, feeding the pooling pipeline input stage. It replaces the fixed-dimension pooling controller and supports any dimension from 2 to MAX_DIM, configurable stride, and back-pressure.

## Interface
- ADDR_W, 5: feature-buffer address width.
- MAX_DIM, 5: largest supported square feature-map side.
- DIM_W, $clog2(MAX_DIM+1): width of the dimension field.
- PAD_ADDR, all ones (ADDR_W bits): address driven on padded lanes.

- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- start  in  1  job request; sampled only in IDLE.
- mode_i  in  1  1 = max, 0 = avg; latched on an accepted start.
- stride1_i  in  1  1 = stride 1, 0 = stride 2; latched on an accepted start.
- dim_i  in  DIM_W  feature-map side N.
- base_i  in  ADDR_W  address of element (0,0).
- busy  out  1  job in progress.
- win_vld  out  1  window outputs valid.
- win_rdy  in  1  pooling pipeline accepts the window.
- addr_o[0:3]  out  ADDR_W each  lanes TL, TR, BL, BR.
- pad_o  out  4  bit k set means lane k is outside the map.
- mode_o  out  1  latched mode.
- last_o  out  1  current window is the final one.
- done  out  1  one-cycle pulse after the final window is accepted.
- err  out  1  one-cycle pulse when start is rejected.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If start and 2 ≤ dim_i ≤ MAX_DIM, latch the configuration, clear r, c and the row base, and go to RUN.
  - If start and dim_i is out of range, pulse err and stay in IDLE.
- RUN: win_vld = 1. A handshake occurs when win_vld && win_rdy.
  - On a handshake, c advances by S, where S = 2 for stride 2 and S = 1 for stride 1.
  - When c+S exceeds the last column, c wraps to 0, r advances by S, and the row base advances by S·N.
- Window origins:
  - Stride 2: r, c ∈ {0, 2, …} while < N; ceil(N/2)² windows.
  - Stride 1: r, c ∈ {0 … N−2}; (N−1)² windows.
- Lane addresses (rb = base + r·N):
  - TL = rb + c.
  - TR = rb + c + 1.
  - BL = rb + N + c.
  - BR = rb + N + c + 1.
  - TR and BR are padded when c+1 ≥ N; BL and BR are padded when r+1 ≥ N.
  - A padded lane drives PAD_ADDR and sets its pad_o bit. Stride 1 never pads.
- All address arithmetic is modulo 2^ADDR_W. The row base is an incrementing register; no multiplier is used.
- last_o is set on the final origin. A handshake on the last window moves the FSM to DONE.
- DONE: pulse done for one cycle, then return to IDLE.
- start in RUN or DONE is ignored (no err).

## Timing
- Reset values: busy, win_vld, last_o, done, err, mode_o = 0; pad_o = 0; addr_o = 0; state IDLE.
- Start accepted at edge k: busy = 1 and the first window is valid after edge k, i.e. one cycle of latency.
- Without stall, one window per cycle. A job of W windows gives done high in the cycle after edge k+W.
- While win_vld && !win_rdy, addr_o, pad_o, and last_o hold stable.
- win_vld never drops without a handshake, except on reset.
- busy stays high through RUN and DONE.
- Reset asserted mid-job aborts immediately to the reset values. No done is issued.

## Configuration
- POOL_STRIDE1_EN:
  - Defined: stride1_i is honoured as described above.
  - Undefined: stride1_i is ignored, stride is fixed at 2, and the stride-1 logic is not synthesised.

## Structure
- Shared package pool_pkg holds the state enum, a pool_cfg_t struct (dim, base, stride1, mode), and lane index constants TL=0, TR=1, BL=2, BR=3.
- One sub-module, pool_win_counter, holds the r/c/row-base counters and produces the last flag. The FSM and padding/address logic stay in the top level.

## Test plan
- N=3, stride 2, base 0, win_rdy=1:
  - Windows {0,1,3,4}, pad 0000.
  - {2,P,5,P}, pad 1010.
  - {6,7,P,P}, pad 1100.
  - {8,P,P,P}, pad 1110, last_o set.
  - done pulses one cycle after the last window.
- N=4, stride 2, base 8: windows {8,9,12,13}, {10,11,14,15}, {16,17,20,21}, {18,19,22,23}; no padding; wrap to 24+ does not occur.
- N=3, stride 1 (macro defined), base 0: windows {0,1,3,4}, {1,2,4,5}, {3,4,6,7}, {4,5,7,8}.
- Back-pressure: N=4, win_rdy low for 3 cycles on window 2 → outputs hold {10,11,14,15}; total windows = 4 and done is delayed by 3 cycles.
- Illegal start: dim_i = 1, then dim_i = MAX_DIM+1 → err pulses each time, busy stays 0, no win_vld.
- Reset mid-job: nrst low during window 2 of N=5 → all outputs at reset values, no done; a new start afterwards begins again at TL = base.
